// File: rtl/wishbone_sram_pkg.sv
// Shared types and helpers for the Wishbone SRAM slave.
package wishbone_sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int lsb_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/wishbone_sram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module wishbone_sram_array #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 1024,
  parameter string INIT_FILE  = "",
  localparam int   BYTES      = DATA_WIDTH / 8,
  localparam int   IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [BYTES-1:0]      we,
  input  logic                  re,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wishbone_sram.sv
// Wishbone classic slave memory: programmable ACK latency, base-address window,
// fixed read pattern outside the window.
module wishbone_sram
  import wishbone_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LATENCY    = 1,
  parameter logic [31:0]           OOR_DATA   = 32'hDEADBEEF,
  parameter string                 INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    WB_CYC,
  input  logic                    WB_STB,
  input  logic                    WB_WE,
  input  logic [ADDR_WIDTH-1:0]   WB_ADDR,
  input  logic [DATA_WIDTH-1:0]   WB_WDATA,
  input  logic [DATA_WIDTH/8-1:0] WB_SEL,
  output logic [DATA_WIDTH-1:0]   WB_RDATA,
  output logic                    WB_ACK
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = lsb_bits(DATA_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   WIN_SIZE = (ADDR_WIDTH+1)'(DEPTH * BYTES);
  localparam logic [DATA_WIDTH-1:0] OOR_WORD = DATA_WIDTH'(OOR_DATA);
  localparam logic [3:0]            CNT_LOAD = 4'(LATENCY - 2);

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       commit;

  logic [ADDR_WIDTH-1:0] live_off;
  logic                  live_in_range;
  logic [IDX_W-1:0]      live_idx;

  logic [IDX_W-1:0]      cap_idx;
  logic                  cap_we;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [BYTES-1:0]      cap_sel;
  logic                  cap_in_range;

  logic [IDX_W-1:0]      cur_idx;
  logic                  cur_we;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [BYTES-1:0]      cur_sel;
  logic                  cur_in_range;

  logic [BYTES-1:0]      ram_we;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  rd_valid;
  logic                  rd_oor;

  assign live_off      = WB_ADDR - BASE_ADDR;
  assign live_in_range = ({1'b0, live_off} < WIN_SIZE);
  assign live_idx      = live_off[LSB +: IDX_W];

  // With LATENCY==1 the accept edge is also the commit edge, so IDLE uses the live bus.
  assign cur_idx      = (state == IDLE) ? live_idx      : cap_idx;
  assign cur_we       = (state == IDLE) ? WB_WE         : cap_we;
  assign cur_wdata    = (state == IDLE) ? WB_WDATA      : cap_wdata;
  assign cur_sel      = (state == IDLE) ? WB_SEL        : cap_sel;
  assign cur_in_range = (state == IDLE) ? live_in_range : cap_in_range;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (WB_CYC && WB_STB) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (!WB_CYC) begin
          state_next = IDLE;
        end else if (cnt == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      WB_ACK   <= 1'b0;
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      WB_ACK <= commit;
      if (commit && !cur_we) begin
        rd_valid <= 1'b1;
        rd_oor   <= !cur_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && WB_CYC && WB_STB) begin
      cap_idx      <= live_idx;
      cap_we       <= WB_WE;
      cap_wdata    <= WB_WDATA;
      cap_sel      <= WB_SEL;
      cap_in_range <= live_in_range;
    end
  end

  assign ram_we = (commit && cur_we && cur_in_range) ? cur_sel : '0;
  assign ram_re = commit && !cur_we && cur_in_range;

  wishbone_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register holds the last in-window read; flags pick it, the pattern, or zero.
  assign WB_RDATA = !rd_valid ? '0 : (rd_oor ? OOR_WORD : ram_rdata);

endmodule

// File: tb/tb_wishbone_sram.sv
// Bench for wishbone_sram: a LATENCY=1 unit at base 0 and a LATENCY=4 unit at 0x8000_0000.
module tb_wishbone_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  sel [2];
  logic [31:0] rdata [2];
  logic        ack [2];

  int total = 0;
  int bad   = 0;

  bit [31:0] mm [2][1024];
  bit [31:0] last_rd [2];

  wishbone_sram #(.LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .WB_CYC(cyc[0]), .WB_STB(stb[0]), .WB_WE(we[0]),
    .WB_ADDR(addr[0]), .WB_WDATA(wdata[0]), .WB_SEL(sel[0]),
    .WB_RDATA(rdata[0]), .WB_ACK(ack[0])
  );

  wishbone_sram #(.LATENCY(4), .BASE_ADDR(32'h8000_0000)) u1 (
    .clk(clk), .rst_n(rst_n), .WB_CYC(cyc[1]), .WB_STB(stb[1]), .WB_WE(we[1]),
    .WB_ADDR(addr[1]), .WB_WDATA(wdata[1]), .WB_SEL(sel[1]),
    .WB_RDATA(rdata[1]), .WB_ACK(ack[1])
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  function automatic bit [31:0] base_of(input int u);
    return (u == 0) ? 32'h0 : 32'h8000_0000;
  endfunction

  function automatic bit in_win(input int u, input bit [31:0] a);
    bit [31:0] off;
    off = a - base_of(u);
    return off < 32'd4096;
  endfunction

  function automatic int widx(input int u, input bit [31:0] a);
    bit [31:0] off;
    off = a - base_of(u);
    return int'(off / 4);
  endfunction

  function automatic bit [31:0] model_read(input int u, input bit [31:0] a);
    return in_win(u, a) ? mm[u][widx(u, a)] : 32'hDEADBEEF;
  endfunction

  task automatic model_write(input int u, input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
    if (in_win(u, a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mm[u][widx(u, a)][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Starts #1 after a rising edge; returns cycles-to-ACK and the data seen with ACK.
  task automatic xact(input int u, input bit w, input bit [31:0] a, input bit [31:0] d,
                      input bit [3:0] s, output bit [31:0] rd, output int n);
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; sel[u] = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack[u] && n < 40);
    rd = rdata[u];
    cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
    @(posedge clk); #1;
    chk("ack_width", {31'b0, ack[u]}, 32'd0);
  endtask

  task automatic do_op(input int u, input bit w, input bit [31:0] a, input bit [31:0] d,
                       input bit [3:0] s, input string nm);
    bit [31:0] exp, rd;
    int n;
    exp = w ? last_rd[u] : model_read(u, a);
    xact(u, w, a, d, s, rd, n);
    chk({nm, "_lat"}, n, lat_of(u));
    chk({nm, "_data"}, rd, exp);
    if (w) model_write(u, a, d, s);
    else   last_rd[u] = exp;
  endtask

  typedef struct {
    int        u;
    bit        w;
    bit [31:0] a;
    bit [31:0] d;
    bit [3:0]  s;
    bit [31:0] exp;
  } vec_t;

  vec_t vt [15];

  initial begin
    bit [31:0] rd;
    int n;
    bit [5:0] pat;
    bit any_ack;

    vt[0]  = '{0, 1'b1, 32'h0000_0010, 32'hA5A5A5A5, 4'hF, 32'h0000_0000};
    vt[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hA5A5A5A5};
    vt[2]  = '{0, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'hF, 32'hA5A5A5A5};
    vt[3]  = '{0, 1'b1, 32'h0000_0020, 32'h00000000, 4'h5, 32'hA5A5A5A5};
    vt[4]  = '{0, 1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'hFF00FF00};
    vt[5]  = '{0, 1'b0, 32'h0000_0013, 32'h0,        4'hF, 32'hA5A5A5A5};
    vt[6]  = '{0, 1'b0, 32'h0000_1000, 32'h0,        4'hF, 32'hDEADBEEF};
    vt[7]  = '{0, 1'b1, 32'h0000_1010, 32'h77777777, 4'hF, 32'hDEADBEEF};
    vt[8]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hA5A5A5A5};
    vt[9]  = '{1, 1'b1, 32'h8000_0000, 32'h11223344, 4'hF, 32'h0000_0000};
    vt[10] = '{1, 1'b1, 32'h8000_0FFC, 32'hCAFEF00D, 4'hF, 32'h0000_0000};
    vt[11] = '{1, 1'b0, 32'h7FFF_FFFC, 32'h0,        4'hF, 32'hDEADBEEF};
    vt[12] = '{1, 1'b1, 32'h8000_1000, 32'h55555555, 4'hF, 32'hDEADBEEF};
    vt[13] = '{1, 1'b0, 32'h8000_0000, 32'h0,        4'hF, 32'h11223344};
    vt[14] = '{1, 1'b0, 32'h8000_0FFD, 32'h0,        4'hF, 32'hCAFEF00D};

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      cyc[u] = 0; stb[u] = 0; we[u] = 0; addr[u] = 0; wdata[u] = 0; sel[u] = 0;
      last_rd[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_ack", {31'b0, ack[u]}, 32'd0);
      chk("reset_rdata", rdata[u], 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      xact(vt[i].u, vt[i].w, vt[i].a, vt[i].d, vt[i].s, rd, n);
      chk($sformatf("vec%0d_lat", i), n, lat_of(vt[i].u));
      chk($sformatf("vec%0d_data", i), rd, vt[i].exp);
      if (vt[i].w) model_write(vt[i].u, vt[i].a, vt[i].d, vt[i].s);
      else         last_rd[vt[i].u] = vt[i].exp;
    end

    // CYC without STB in IDLE must not start an access
    cyc[0] = 1'b1; stb[0] = 1'b0; addr[0] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("cyc_no_stb", {31'b0, ack[0]}, 32'd0);
    end
    cyc[0] = 1'b0;

    // STB held high: requests seen in RESP are ignored, so ACK alternates
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat = {pat[4:0], ack[0]};
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    chk("turnaround", {26'b0, pat}, 32'b101010);
    chk("turnaround_data", rdata[0], 32'hA5A5A5A5);
    last_rd[0] = 32'hA5A5A5A5;
    @(posedge clk); #1;

    // CYC dropped in cycle 2 of a LATENCY=4 write: no ACK, no commit
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8000_0000;
    wdata[1] = 32'hBAD0BAD0; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    any_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      any_ack |= ack[1];
    end
    chk("abort_no_ack", {31'b0, any_ack}, 32'd0);
    do_op(1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, "abort_rd");

    // Bus changes after the accept edge must not affect the access
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8000_0004;
    wdata[1] = 32'h01020304; sel[1] = 4'hF;
    @(posedge clk); #1;
    addr[1] = 32'h8000_0008; wdata[1] = 32'hFFFFFFFF; sel[1] = 4'h0;
    n = 1;
    while (!ack[1] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    chk("hold_lat", n, 4);
    model_write(1, 32'h8000_0004, 32'h01020304, 4'hF);
    @(posedge clk); #1;
    do_op(1, 1'b0, 32'h8000_0004, 32'h0, 4'hF, "hold_rd");

    // Asynchronous reset in the middle of a write
    do_op(1, 1'b1, 32'h8000_0040, 32'h40404040, 4'hF, "pre_rst_wr");
    do_op(1, 1'b0, 32'h8000_0040, 32'h0, 4'hF, "pre_rst_rd");
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8000_0040;
    wdata[1] = 32'h99999999; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'b0, ack[1]}, 32'd0);
    chk("rst_mid_rdata1", rdata[1], 32'd0);
    chk("rst_mid_rdata0", rdata[0], 32'd0);
    repeat (2) @(posedge clk);
    #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    rst_n = 1'b1;
    last_rd[0] = 0;
    last_rd[1] = 0;
    @(posedge clk); #1;
    do_op(1, 1'b0, 32'h8000_0040, 32'h0, 4'hF, "post_rst_rd");

    // Randomized traffic against the reference model
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 16; k++)
        do_op(u, 1'b1, base_of(u) + 32'(k * 4), $urandom, 4'hF, "rnd_init");
      for (int k = 0; k < 80; k++) begin
        bit [31:0] a;
        if ($urandom_range(7) == 0)
          a = base_of(u) - 32'(4 * (1 + $urandom_range(7)));
        else
          a = base_of(u) + 32'($urandom_range(15) * 4) + 32'($urandom_range(3));
        do_op(u, 1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
